// File: rtl/joystick_decoder.sv
// joystick_decoder: averages per-axis ADC samples into smoothed X/Y positions,
// derives dead-zoned direction flags and reports a stale stream.
// Ports:
//   clk_in       system clock, rising edge
//   reset        asynchronous active-low reset
//   sample_in    8-bit conversion result
//   sample_ch    axis tag (0 = X, 1 = Y)
//   sample_valid one-cycle strobe qualifying sample_in/sample_ch
//   x_pos/y_pos  averaged positions
//   left/right/up/down  direction flags
//   upd          one-cycle pulse when flags or positions changed
//   stale        high while no sample arrived for TIMEOUT cycles
// Build option: define JOY_HYST_EN to release flags only inside CENTER+/-DEAD_OFF.
module joystick_decoder #(
  parameter int AVG_LOG2 = 2,
  parameter int CENTER   = 128,
  parameter int DEAD_ON  = 48,
  parameter int DEAD_OFF = 32,
  parameter int TIMEOUT  = 1000000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [7:0] sample_in,
  input  logic       sample_ch,
  input  logic       sample_valid,
  output logic [7:0] x_pos,
  output logic [7:0] y_pos,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       upd,
  output logic       stale
);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam int AW = 8 + AVG_LOG2;
  localparam logic [9:0] C10 = 10'(CENTER);
  localparam logic [9:0] ON10 = 10'(DEAD_ON);
  localparam logic [9:0] OFF10 = 10'(DEAD_OFF);
`ifdef JOY_HYST_EN
  localparam logic HYST = 1'b1;
`else
  localparam logic HYST = 1'b0;
`endif
  typedef enum logic {S_STALE, S_RUN} state_t;
  state_t r_state, w_state_nx;
  logic [WD_W-1:0] r_wd;
  logic [AW-1:0] r_acc [2];
  logic [AVG_LOG2-1:0] r_cnt [2];
  logic [7:0] r_pos [2];
  logic [3:0] r_flags, w_flags_nx;
  logic r_upd, r_pos_chg, w_expire, w_done;
  logic [AW-1:0] w_sum;
  logic [7:0] w_avg;
  logic [9:0] w_x, w_y;
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) r_state <= S_STALE;
    else r_state <= w_state_nx;
  always_comb begin
    w_expire = r_state == S_RUN && !sample_valid && r_wd == WD_W'(TIMEOUT - 1);
    w_state_nx = sample_valid ? S_RUN : (w_expire ? S_STALE : r_state);
    w_sum = r_acc[sample_ch] + AW'(sample_in);
    w_done = &r_cnt[sample_ch];
    w_avg = w_sum[AVG_LOG2 +: 8];
    w_x = {2'b0, r_pos[0]};
    w_y = {2'b0, r_pos[1]};
    // a held flag uses the release threshold, an idle one the assert threshold
    w_flags_nx[3] = w_x + (HYST && r_flags[3] ? OFF10 : ON10) <= C10;
    w_flags_nx[2] = w_x >= C10 + (HYST && r_flags[2] ? OFF10 : ON10);
    w_flags_nx[1] = w_y + (HYST && r_flags[1] ? OFF10 : ON10) <= C10;
    w_flags_nx[0] = w_y >= C10 + (HYST && r_flags[0] ? OFF10 : ON10);
  end
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_wd <= '0;
      r_acc <= '{default: '0};
      r_cnt <= '{default: '0};
      r_pos <= '{default: 8'(CENTER)};
      r_flags <= '0;
      r_upd <= 1'b0;
      r_pos_chg <= 1'b0;
    end else if (w_expire) begin
      r_wd <= '0;
      r_acc <= '{default: '0};
      r_cnt <= '{default: '0};
      r_pos <= '{default: 8'(CENTER)};
      r_flags <= '0;
      r_upd <= |r_flags;
      r_pos_chg <= 1'b0;
    end else begin
      r_wd <= (sample_valid || r_state == S_STALE) ? '0 : r_wd + 1'b1;
      r_flags <= w_flags_nx;
      // a position change is announced together with the flags it produces
      r_upd <= r_pos_chg || w_flags_nx != r_flags;
      r_pos_chg <= 1'b0;
      if (sample_valid) begin
        r_acc[sample_ch] <= w_done ? '0 : w_sum;
        r_cnt[sample_ch] <= r_cnt[sample_ch] + 1'b1;
        if (w_done) begin
          r_pos[sample_ch] <= w_avg;
          r_pos_chg <= w_avg != r_pos[sample_ch];
        end
      end
    end
  end
  assign x_pos = r_pos[0];
  assign y_pos = r_pos[1];
  assign {left, right, up, down} = r_flags;
  assign upd = r_upd;
  assign stale = r_state == S_STALE;
endmodule

// File: tb/tb_joystick_decoder.sv
// tb_joystick_decoder: directed stimulus with a queue-based reference model checked every cycle
module tb_joystick_decoder;
  localparam int AVG_LOG2 = 2;
  localparam int N = 1 << AVG_LOG2;
  localparam int CENTER = 128;
  localparam int DEAD_ON = 48;
  localparam int DEAD_OFF = 32;
  localparam int TIMEOUT = 40;
`ifdef JOY_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] sample_in = '0;
  logic sample_ch = 1'b0;
  logic sample_valid = 1'b0;
  logic [7:0] x_pos, y_pos;
  logic left, right, up, down, upd, stale;
  int checks = 0;
  int errors = 0;
  joystick_decoder #(.AVG_LOG2(AVG_LOG2), .CENTER(CENTER), .DEAD_ON(DEAD_ON),
                     .DEAD_OFF(DEAD_OFF), .TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk), .reset(reset), .sample_in(sample_in), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .x_pos(x_pos), .y_pos(y_pos), .left(left),
    .right(right), .up(up), .down(down), .upd(upd), .stale(stale));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  int qx[$];
  int qy[$];
  int m_pos[2] = '{CENTER, CENTER};
  int m_idle = 0;
  bit m_stale = 1'b1;
  bit [3:0] m_flag = '0;
  bit m_upd = 1'b0;
  bit m_chg = 1'b0;
  function automatic int mean(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s / q.size();
  endfunction
  function automatic bit [3:0] rule(input int x, input int y, input bit [3:0] f);
    int off = HYST ? DEAD_OFF : DEAD_ON;
    rule[3] = x <= CENTER - (f[3] ? off : DEAD_ON);
    rule[2] = x >= CENTER + (f[2] ? off : DEAD_ON);
    rule[1] = y <= CENTER - (f[1] ? off : DEAD_ON);
    rule[0] = y >= CENTER + (f[0] ? off : DEAD_ON);
  endfunction
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      qx.delete();
      qy.delete();
      m_pos = '{CENTER, CENTER};
      m_idle = 0;
      m_stale = 1'b1;
      m_flag = '0;
      m_upd = 1'b0;
      m_chg = 1'b0;
    end else if (!m_stale && !sample_valid && m_idle + 1 == TIMEOUT) begin
      m_upd = |m_flag;
      m_flag = '0;
      m_pos = '{CENTER, CENTER};
      qx.delete();
      qy.delete();
      m_chg = 1'b0;
      m_stale = 1'b1;
      m_idle = 0;
    end else begin
      bit [3:0] nf;
      int np;
      nf = rule(m_pos[0], m_pos[1], m_flag);
      m_upd = nf != m_flag || m_chg;
      m_flag = nf;
      m_chg = 1'b0;
      if (sample_valid) begin
        m_idle = 0;
        m_stale = 1'b0;
        if (sample_ch) qy.push_back(int'(sample_in));
        else qx.push_back(int'(sample_in));
        if (qx.size() == N) begin
          np = mean(qx);
          m_chg = np != m_pos[0];
          m_pos[0] = np;
          qx.delete();
        end
        if (qy.size() == N) begin
          np = mean(qy);
          m_chg = np != m_pos[1];
          m_pos[1] = np;
          qy.delete();
        end
      end else if (!m_stale) m_idle++;
    end
  end
  always @(negedge clk) if (reset) begin
    chk("model x_pos", x_pos, m_pos[0]);
    chk("model y_pos", y_pos, m_pos[1]);
    chk("model flags", {left, right, up, down}, m_flag);
    chk("model upd", upd, m_upd);
    chk("model stale", stale, m_stale);
  end
  task automatic put(input logic ch, input int v);
    sample_valid = 1'b1;
    sample_ch = ch;
    sample_in = 8'(v);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask
  task automatic put4(input logic ch, input int v);
    repeat (N) put(ch, v);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset stale", stale, 1);
    chk("reset x_pos", x_pos, CENTER);
    chk("reset y_pos", y_pos, CENTER);
    chk("reset flags", {left, right, up, down}, 0);
    chk("reset upd", upd, 0);
    reset = 1'b1;
    @(negedge clk);
    put(0, 200);
    chk("stale drops", stale, 0);
    repeat (N - 1) put(0, 200);
    chk("avg 200 x_pos", x_pos, 200);
    chk("right not yet", right, 0);
    @(negedge clk);
    chk("right set", right, 1);
    chk("right upd", upd, 1);
    @(negedge clk);
    chk("upd one cycle", upd, 0);
    for (int i = 0; i < N; i++) begin
      put(0, 10);
      put(1, 128);
    end
    repeat (2) @(negedge clk);
    chk("interleave x_pos", x_pos, 10);
    chk("interleave y_pos", y_pos, 128);
    chk("interleave flags", {left, right, up, down}, 4'b1000);
    put4(0, 200);
    repeat (2) @(negedge clk);
    chk("settle right", right, 1);
    put4(0, 170);
    repeat (2) @(negedge clk);
    chk("170 right", right, HYST ? 1 : 0);
    put4(0, 155);
    @(negedge clk);
    chk("155 right", right, 0);
    chk("155 upd", upd, 1);
    put(0, 1);
    repeat (N - 1) put(0, 2);
    chk("truncate", x_pos, 1);
    put4(0, 255);
    chk("max avg", x_pos, 255);
    put4(0, 200);
    @(negedge clk);
    chk("pre-timeout right", right, 1);
    repeat (TIMEOUT - 2) @(negedge clk);
    chk("just before expiry", stale, 0);
    @(negedge clk);
    chk("expiry stale", stale, 1);
    chk("expiry right", right, 0);
    chk("expiry x_pos", x_pos, CENTER);
    chk("expiry upd", upd, 1);
    @(negedge clk);
    chk("expiry upd once", upd, 0);
    put(0, 200);
    repeat (TIMEOUT - 1) @(negedge clk);
    put(0, 200);
    chk("sample wins", stale, 0);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("watchdog restarted", stale, 0);
    @(negedge clk);
    chk("second expiry", stale, 1);
    put(0, 100);
    put(0, 100);
    #2 reset = 1'b0;
    #1;
    chk("reset mid x_pos", x_pos, CENTER);
    chk("reset mid upd", upd, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    put4(0, 60);
    chk("fresh avg", x_pos, 60);
    @(negedge clk);
    chk("fresh left", left, 1);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
